// File: rtl/lcd_field_scheduler_pkg.sv
// Shared definitions for the LCD1602 dynamic-field scheduler.
//   state_t        : scheduler FSM states
//   LCD_INIT_WAIT  : default power-up wait (50 ms @ 50 MHz)
//   LCD_MIN_GAP    : default hold-off after each accepted transfer
//   cnt_width()    : width of the shared wait/gap counter
package lcd_field_scheduler_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_OFFER = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int unsigned LCD_INIT_WAIT = 2500000;
  localparam int unsigned LCD_MIN_GAP   = 800000;

  // Counter only ever reaches max(a,b)-1, so clog2(max) bits suffice.
  // A floor of 2 keeps the width at least one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_field_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   i_pending    : one bit per producer with a value waiting
//   i_last_grant : producer served most recently
//   o_any        : at least one producer pending
//   o_grant      : first pending index scanning last_grant+1, +2, ... modulo NUM_REQ
module lcd_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_grant
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    o_any   = 1'b0;
    o_grant = '0;
    // Offsets 1..NUM_REQ put last_grant itself at the lowest priority.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(i_last_grant) + k;
      idx = idx % NUM_REQ;
      if (!o_any && i_pending[idx]) begin
        o_any   = 1'b1;
        o_grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lcd_field_scheduler.sv
// Shares the LCD1602 dynamic-field write path among NUM_REQ value producers.
// One pending slot per producer; slots are served round-robin and offered one
// (field, value) at a time over valid/ready, with MIN_GAP cycles of hold-off
// after every accepted transfer. lcd_start_o rises (sticky) INIT_WAIT cycles
// after reset to release the LCD controller.
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low
//   req_valid   : producer i presents a value
//   req_value   : producer i value in bits [i*VAL_W +: VAL_W]
//   req_ready   : slot i empty (registered, no path from out_ready)
//   out_valid   : offer to LCD side is valid
//   out_ready   : LCD side accepts offer
//   out_field   : producer index of the current offer
//   out_value   : value of the current offer
//   lcd_start_o : LCD controller start strobe
module lcd_field_scheduler
  import lcd_field_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned VAL_W     = 16,
  parameter int unsigned INIT_WAIT = LCD_INIT_WAIT,
  parameter int unsigned MIN_GAP   = LCD_MIN_GAP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*VAL_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_field,
  output logic [VAL_W-1:0]           out_value,
  output logic                       lcd_start_o
);

  localparam int unsigned          IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned          CNT_W     = cnt_width(INIT_WAIT, MIN_GAP);
  localparam logic [CNT_W-1:0]     INIT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(MIN_GAP - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_state_next;

  logic [NUM_REQ-1:0] r_pending;
  logic [VAL_W-1:0]   r_slot [NUM_REQ];
  logic [IDX_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_out_valid;
  logic [IDX_W-1:0]   r_out_field;
  logic [VAL_W-1:0]   r_out_value;
  logic               r_lcd_start;

  logic               w_any;
  logic [IDX_W-1:0]   w_grant;
  logic               w_offer_load;
  logic               w_xfer;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_start_set;

  lcd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_pending    (r_pending),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_offer_load = 1'b0;
    w_xfer       = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_start_set  = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (r_cnt == INIT_LAST) begin
          w_start_set  = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_IDLE: begin
        if (w_any) begin
          w_offer_load = 1'b1;
          w_state_next = S_OFFER;
        end
      end
      S_OFFER: begin
        if (r_out_valid && out_ready) begin
          w_xfer       = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_clr    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_next = S_INIT;
    endcase
  end

  // ------------------------------------------- counter and offer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_field  <= '0;
      r_out_value  <= '0;
      r_lcd_start  <= 1'b0;
      r_last_grant <= LAST_IDX;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_start_set) begin
        r_lcd_start <= 1'b1;
      end

      if (w_offer_load) begin
        r_out_valid <= 1'b1;
        r_out_field <= w_grant;
        r_out_value <= r_slot[w_grant];
      end else if (w_xfer) begin
        r_out_valid  <= 1'b0;
        r_last_grant <= r_out_field;
      end
    end
  end

  // ------------------------------------------------------------- slots
  // The slot under offer is still pending, so it cannot capture; clearing it
  // on transfer and capturing into any other slot can happen on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_xfer && (r_out_field == IDX_W'(i))) begin
          r_pending[i] <= 1'b0;
        end else if (req_valid[i] && !r_pending[i]) begin
          r_pending[i] <= 1'b1;
          r_slot[i]    <= req_value[i*VAL_W +: VAL_W];
        end
      end
    end
  end

  assign req_ready   = ~r_pending;
  assign out_valid   = r_out_valid;
  assign out_field   = r_out_field;
  assign out_value   = r_out_value;
  assign lcd_start_o = r_lcd_start;

endmodule
